// File: rtl/register_write_queue_if.sv
// Bus bundle between the SPI-side command source / commit controller and register_write_queue.
// REGISTER_WRITE_QUEUE_DROP_COUNT_EN adds the o_DropCount status output.
interface register_write_queue_if #(
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 16
);
    localparam int DEPTH_WIDTH = $clog2(DEPTH) + 1;

    logic                   i_RegisterWriteEnable;
    logic [ADDR_WIDTH-1:0]  i_RegisterWriteNumber;
    logic [DATA_WIDTH-1:0]  i_RegisterWriteValue;
    logic                   i_CommitWindow;
    logic                   o_ParamWriteEnable;
    logic [ADDR_WIDTH-1:0]  o_ParamAddress;
    logic [DATA_WIDTH-1:0]  o_ParamValue;
    logic [DEPTH_WIDTH-1:0] o_Depth;
    logic                   o_Overflow;
`ifdef REGISTER_WRITE_QUEUE_DROP_COUNT_EN
    logic [7:0]             o_DropCount;
`endif

    modport master (
        output i_RegisterWriteEnable, i_RegisterWriteNumber, i_RegisterWriteValue, i_CommitWindow,
`ifdef REGISTER_WRITE_QUEUE_DROP_COUNT_EN
        input  o_DropCount,
`endif
        input  o_ParamWriteEnable, o_ParamAddress, o_ParamValue, o_Depth, o_Overflow
    );

    modport slave (
        input  i_RegisterWriteEnable, i_RegisterWriteNumber, i_RegisterWriteValue, i_CommitWindow,
`ifdef REGISTER_WRITE_QUEUE_DROP_COUNT_EN
        output o_DropCount,
`endif
        output o_ParamWriteEnable, o_ParamAddress, o_ParamValue, o_Depth, o_Overflow
    );
endinterface

// File: rtl/register_write_queue.sv
// Edge-detects SPI write commands, queues them and replays one per cycle during the commit window.
// Optional REGISTER_WRITE_QUEUE_DROP_COUNT_EN adds a saturating dropped-write counter (o_DropCount).
module register_write_queue #(
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 16
) (
    input logic                  i_Clock,
    input logic                  i_Reset,
    register_write_queue_if.slave bus
);
    localparam int                 PTR_WIDTH  = $clog2(DEPTH);
    localparam logic [PTR_WIDTH:0] FULL_COUNT = (PTR_WIDTH + 1)'(DEPTH);
    localparam logic [PTR_WIDTH:0] PTR_ONE    = (PTR_WIDTH + 1)'(1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t                mem_q [DEPTH];
    entry_t                head;
    logic                  enable_last_q;
    logic [PTR_WIDTH:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_WIDTH:0]    count;
    logic                  param_we_q, param_we_d;
    logic [ADDR_WIDTH-1:0] param_addr_q, param_addr_d;
    logic [DATA_WIDTH-1:0] param_value_q, param_value_d;
    logic                  overflow_q, overflow_d;
    logic                  new_cmd, flush, push_req, full, empty, pop, push, drop;

    // The extra pointer bit separates full (MSBs differ) from empty (pointers equal).
    assign count    = wr_ptr_q - rd_ptr_q;
    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign head     = mem_q[rd_ptr_q[PTR_WIDTH-1:0]];

    assign new_cmd  = bus.i_RegisterWriteEnable & ~enable_last_q;
    assign flush    = new_cmd & (&bus.i_RegisterWriteNumber);
    assign push_req = new_cmd & ~flush;
    assign pop      = bus.i_CommitWindow & ~empty & ~flush;
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

`ifdef REGISTER_WRITE_QUEUE_DROP_COUNT_EN
    logic [7:0] drop_count_q, drop_count_d;
    assign bus.o_DropCount = drop_count_q;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        param_we_d    = pop;
        param_addr_d  = param_addr_q;
        param_value_d = param_value_q;
        overflow_d    = overflow_q;
`ifdef REGISTER_WRITE_QUEUE_DROP_COUNT_EN
        drop_count_d  = drop_count_q;
`endif
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop) begin
            rd_ptr_d      = rd_ptr_q + PTR_ONE;
            param_addr_d  = head.addr;
            param_value_d = head.data;
        end
        if (flush) begin
            rd_ptr_d   = wr_ptr_q;
            overflow_d = 1'b0;
`ifdef REGISTER_WRITE_QUEUE_DROP_COUNT_EN
            drop_count_d = '0;
`endif
        end else if (drop) begin
            overflow_d = 1'b1;
`ifdef REGISTER_WRITE_QUEUE_DROP_COUNT_EN
            if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
`endif
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            // A level already high at reset release must not look like a fresh command.
            enable_last_q <= 1'b1;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            param_we_q    <= 1'b0;
            param_addr_q  <= '0;
            param_value_q <= '0;
            overflow_q    <= 1'b0;
`ifdef REGISTER_WRITE_QUEUE_DROP_COUNT_EN
            drop_count_q  <= '0;
`endif
        end else begin
            // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
            enable_last_q <= bus.i_RegisterWriteEnable;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            param_we_q    <= param_we_d;
            param_addr_q  <= param_addr_d;
            param_value_q <= param_value_d;
            overflow_q    <= overflow_d;
`ifdef REGISTER_WRITE_QUEUE_DROP_COUNT_EN
            drop_count_q  <= drop_count_d;
`endif
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge i_Clock) begin
        if (push) mem_q[wr_ptr_q[PTR_WIDTH-1:0]] <= '{addr: bus.i_RegisterWriteNumber,
                                                     data: bus.i_RegisterWriteValue};
    end

    assign bus.o_ParamWriteEnable = param_we_q;
    assign bus.o_ParamAddress     = param_addr_q;
    assign bus.o_ParamValue       = param_value_q;
    assign bus.o_Depth            = count;
    assign bus.o_Overflow         = overflow_q;
endmodule

// File: tb/tb_register_write_queue.sv
// Scoreboard bench for register_write_queue: expected commits are queued at stimulus time
// and popped whenever the DUT strobes a parameter write.
module tb_register_write_queue;
    localparam int DEPTH = 8;
    localparam int AW    = 15;
    localparam int DW    = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cycle_cnt = 0;
    int   strobe_cnt = 0;
    int   last_strobe_cycle = -1;

    register_write_queue_if #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    register_write_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .i_Clock (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Advance one cycle, sample just after the edge and drain the scoreboard on each strobe.
    task automatic tick();
        exp_t exp;
        @(posedge clk);
        #1;
        cycle_cnt++;
        if (bus.o_ParamWriteEnable === 1'b1) begin
            strobe_cnt++;
            last_strobe_cycle = cycle_cnt;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got addr=%h value=%h, required no strobe",
                         bus.o_ParamAddress, bus.o_ParamValue);
            end else begin
                exp = sb.pop_front();
                if ({bus.o_ParamAddress, bus.o_ParamValue} !== exp) begin
                    errors++;
                    $display("FAIL commit_data: got addr=%h value=%h, required addr=%h value=%h",
                             bus.o_ParamAddress, bus.o_ParamValue, exp.addr, exp.data);
                end
            end
        end
    endtask

    // One full command: rising edge, then enable dropped for a cycle.
    task automatic write_cmd(input logic [AW-1:0] addr, input logic [DW-1:0] data, input bit queued);
        bus.i_RegisterWriteEnable = 1'b1;
        bus.i_RegisterWriteNumber = addr;
        bus.i_RegisterWriteValue  = data;
        if (queued) sb.push_back('{addr: addr, data: data});
        tick();
        bus.i_RegisterWriteEnable = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        bus.i_RegisterWriteEnable = 1'b1;
        bus.i_RegisterWriteNumber = 15'h0055;
        bus.i_RegisterWriteValue  = 16'h5555;
        bus.i_CommitWindow        = 1'b1;
        rst = 1'b1;
        #3;
        checks++;
        if ({bus.o_ParamWriteEnable, bus.o_ParamAddress, bus.o_ParamValue} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got we=%b addr=%h value=%h, required all 0",
                     bus.o_ParamWriteEnable, bus.o_ParamAddress, bus.o_ParamValue);
        end
        checks++;
        if (bus.o_Depth !== CW'(0) || bus.o_Overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: got depth=%0d overflow=%b, required 0/0", bus.o_Depth, bus.o_Overflow);
        end
`ifdef REGISTER_WRITE_QUEUE_DROP_COUNT_EN
        checks++;
        if (bus.o_DropCount !== 8'd0) begin
            errors++;
            $display("FAIL reset_drop_count: got %0d, required 0", bus.o_DropCount);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if (bus.o_Depth !== CW'(0)) begin
            errors++;
            $display("FAIL held_at_release: got depth=%0d, required 0", bus.o_Depth);
        end
        bus.i_RegisterWriteEnable = 1'b0;
        bus.i_CommitWindow        = 1'b0;
        tick();
    endtask

    task automatic test_held_level();
        int start = cycle_cnt;
        int s0    = strobe_cnt;
        bus.i_CommitWindow        = 1'b1;
        bus.i_RegisterWriteEnable = 1'b1;
        bus.i_RegisterWriteNumber = 15'h0012;
        bus.i_RegisterWriteValue  = 16'hBEEF;
        sb.push_back('{addr: 15'h0012, data: 16'hBEEF});
        repeat (40) tick();
        checks++;
        if (strobe_cnt - s0 != 1) begin
            errors++;
            $display("FAIL held_single_strobe: got %0d strobes, required 1", strobe_cnt - s0);
        end
        checks++;
        if (last_strobe_cycle != start + 2) begin
            errors++;
            $display("FAIL held_latency: got strobe cycle %0d, required %0d", last_strobe_cycle, start + 2);
        end
        bus.i_RegisterWriteEnable = 1'b0;
        bus.i_CommitWindow        = 1'b0;
        tick();
    endtask

    task automatic test_fifo_order();
        int s0;
        write_cmd(15'h0001, 16'h1111, 1'b1);
        write_cmd(15'h0002, 16'h2222, 1'b1);
        write_cmd(15'h0003, 16'h3333, 1'b1);
        checks++;
        if (bus.o_Depth !== CW'(3)) begin
            errors++;
            $display("FAIL order_depth: got %0d, required 3", bus.o_Depth);
        end
        s0 = strobe_cnt;
        bus.i_CommitWindow = 1'b1;
        repeat (3) tick();
        checks++;
        if (strobe_cnt - s0 != 3 || bus.o_Depth !== CW'(0)) begin
            errors++;
            $display("FAIL order_burst: got %0d strobes depth=%0d, required 3 strobes depth=0",
                     strobe_cnt - s0, bus.o_Depth);
        end
        bus.i_CommitWindow = 1'b0;
        tick();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH + 1; i++)
            write_cmd(AW'(16 + i), DW'(16'hC000 + i), i < DEPTH);
        checks++;
        if (bus.o_Depth !== CW'(DEPTH) || bus.o_Overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_state: got depth=%0d overflow=%b, required 8/1", bus.o_Depth, bus.o_Overflow);
        end
`ifdef REGISTER_WRITE_QUEUE_DROP_COUNT_EN
        checks++;
        if (bus.o_DropCount !== 8'd1) begin
            errors++;
            $display("FAIL drop_count: got %0d, required 1", bus.o_DropCount);
        end
`endif
        bus.i_CommitWindow = 1'b1;
        repeat (12) tick();
        bus.i_CommitWindow = 1'b0;
        checks++;
        if (sb.size() != 0 || bus.o_Depth !== CW'(0) || bus.o_Overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_drain: got pending=%0d depth=%0d overflow=%b, required 0/0/1",
                     sb.size(), bus.o_Depth, bus.o_Overflow);
        end
        write_cmd(15'h7FFF, 16'h0000, 1'b0);
        checks++;
        if (bus.o_Overflow !== 1'b0) begin
            errors++;
            $display("FAIL flush_clears_overflow: got %b, required 0", bus.o_Overflow);
        end
`ifdef REGISTER_WRITE_QUEUE_DROP_COUNT_EN
        checks++;
        if (bus.o_DropCount !== 8'd0) begin
            errors++;
            $display("FAIL flush_clears_drop_count: got %0d, required 0", bus.o_DropCount);
        end
`endif
    endtask

    task automatic test_full_push_pop();
        int s0;
        for (int i = 0; i < DEPTH; i++)
            write_cmd(AW'(32 + i), DW'(16'hD000 + i), 1'b1);
        s0 = strobe_cnt;
        bus.i_RegisterWriteEnable = 1'b1;
        bus.i_RegisterWriteNumber = 15'h0100;
        bus.i_RegisterWriteValue  = 16'hA5A5;
        bus.i_CommitWindow        = 1'b1;
        sb.push_back('{addr: 15'h0100, data: 16'hA5A5});
        tick();
        bus.i_CommitWindow        = 1'b0;
        bus.i_RegisterWriteEnable = 1'b0;
        tick();
        checks++;
        if (bus.o_Depth !== CW'(DEPTH) || bus.o_Overflow !== 1'b0 || strobe_cnt - s0 != 1) begin
            errors++;
            $display("FAIL full_push_pop: got depth=%0d overflow=%b strobes=%0d, required 8/0/1",
                     bus.o_Depth, bus.o_Overflow, strobe_cnt - s0);
        end
        bus.i_CommitWindow = 1'b1;
        repeat (12) tick();
        bus.i_CommitWindow = 1'b0;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL full_drain: got %0d entries never committed, required 0", sb.size());
        end
    endtask

    task automatic test_flush();
        int s0;
        for (int i = 0; i < 4; i++)
            write_cmd(AW'(64 + i), DW'(16'hE000 + i), 1'b1);
        checks++;
        if (bus.o_Depth !== CW'(4)) begin
            errors++;
            $display("FAIL flush_prefill: got depth=%0d, required 4", bus.o_Depth);
        end
        s0 = strobe_cnt;
        bus.i_RegisterWriteEnable = 1'b1;
        bus.i_RegisterWriteNumber = 15'h7FFF;
        bus.i_RegisterWriteValue  = 16'h0000;
        bus.i_CommitWindow        = 1'b1;
        tick();
        checks++;
        if (bus.o_Depth !== CW'(0) || bus.o_Overflow !== 1'b0 || strobe_cnt != s0) begin
            errors++;
            $display("FAIL flush_effect: got depth=%0d overflow=%b strobes=%0d, required 0/0/0",
                     bus.o_Depth, bus.o_Overflow, strobe_cnt - s0);
        end
        sb.delete();
        bus.i_RegisterWriteEnable = 1'b0;
        repeat (6) tick();
        checks++;
        if (strobe_cnt != s0) begin
            errors++;
            $display("FAIL flush_no_replay: got %0d strobes, required 0", strobe_cnt - s0);
        end
        bus.i_CommitWindow = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_replay();
        int s0;
        write_cmd(15'h0021, 16'h2101, 1'b1);
        write_cmd(15'h0022, 16'h2202, 1'b1);
        bus.i_RegisterWriteEnable = 1'b1;
        bus.i_RegisterWriteNumber = 15'h0023;
        bus.i_RegisterWriteValue  = 16'h2303;
        sb.push_back('{addr: 15'h0023, data: 16'h2303});
        tick();
        bus.i_CommitWindow = 1'b1;
        tick();
        rst = 1'b1;
        #2;
        checks++;
        if ({bus.o_ParamWriteEnable, bus.o_ParamAddress, bus.o_ParamValue} !== '0
            || bus.o_Depth !== CW'(0) || bus.o_Overflow !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got we=%b addr=%h value=%h depth=%0d overflow=%b, required all 0",
                     bus.o_ParamWriteEnable, bus.o_ParamAddress, bus.o_ParamValue, bus.o_Depth, bus.o_Overflow);
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        s0 = strobe_cnt;
        repeat (5) tick();
        checks++;
        if (strobe_cnt != s0 || bus.o_Depth !== CW'(0)) begin
            errors++;
            $display("FAIL held_after_reset: got strobes=%0d depth=%0d, required 0/0", strobe_cnt - s0, bus.o_Depth);
        end
        bus.i_RegisterWriteEnable = 1'b0;
        tick();
        bus.i_RegisterWriteEnable = 1'b1;
        bus.i_RegisterWriteNumber = 15'h0044;
        bus.i_RegisterWriteValue  = 16'h4444;
        sb.push_back('{addr: 15'h0044, data: 16'h4444});
        repeat (3) tick();
        checks++;
        if (strobe_cnt - s0 != 1 || sb.size() != 0) begin
            errors++;
            $display("FAIL rearm_after_reset: got strobes=%0d pending=%0d, required 1/0", strobe_cnt - s0, sb.size());
        end
        bus.i_RegisterWriteEnable = 1'b0;
        bus.i_CommitWindow        = 1'b0;
        tick();
    endtask

    initial begin
        bus.i_RegisterWriteEnable = 1'b0;
        bus.i_RegisterWriteNumber = '0;
        bus.i_RegisterWriteValue  = '0;
        bus.i_CommitWindow        = 1'b0;
        test_reset();
        test_held_level();
        test_fifo_order();
        test_overflow();
        test_full_push_pop();
        test_flush();
        test_reset_mid_replay();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
